signal_controller: RTL and testbench
====================================

SIGNAL_CONTROLLER -- requirements
Module: signal_controller

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter Y2R_DELAY, default 3: yellow dwell in clock cycles; legal values are 1..255.
REQ-003 Parameter R2G_DELAY, default 2: all-red dwell in clock cycles; legal values are 1..255.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port clear, input, 1 bit: synchronous active-high reset.
REQ-006 Port x, input, 1 bit: country-road car sensor; 1 means a car is waiting.
REQ-007 Port hwy, output, 2 bits: highway light code.
REQ-008 Port cntry, output, 2 bits: country-road light code.
REQ-009 The port order SHALL be hwy, cntry, x, clear, clk, so that positional instantiation works.

Function
REQ-010 Light codes SHALL be RED=2'd0, YELLOW=2'd1, GREEN=2'd2; code 2'd3 SHALL never be driven.
REQ-011 The controller SHALL be a Moore FSM with five states and outputs decoded from the state register only:
- S0: hwy GREEN, cntry RED.
- S1: hwy YELLOW, cntry RED.
- S2: hwy RED, cntry RED.
- S3: hwy RED, cntry GREEN.
- S4: hwy RED, cntry YELLOW.
REQ-012 In S0, if x is 1 at a rising edge, the FSM SHALL go to S1; otherwise it SHALL stay in S0.
REQ-013 S1 SHALL last exactly Y2R_DELAY cycles and then go to S2; x is ignored in S1.
REQ-014 S2 SHALL last exactly R2G_DELAY cycles and then go to S3; x is ignored in S2.
REQ-015 In S3, if x is 0 at a rising edge, the FSM SHALL go to S4; otherwise it SHALL stay in S3, with no timeout.
REQ-016 S4 SHALL last exactly Y2R_DELAY cycles and then go to S0; x is ignored in S4.
REQ-017 S0 SHALL last at least one cycle; if x is still 1 on return to S0, the FSM SHALL go to S1 at the next edge.
REQ-018 The dwell counter SHALL clear on every state entry, and a timed state SHALL exit at the edge where the count equals DELAY-1.
REQ-019 Default latency: with x=1 sampled at edge k, the outputs SHALL be S1 during cycles k..k+2, S2 during k+3..k+4, and S3 from k+5.
REQ-020 x SHALL be sampled only at the rising clock edge; glitches between edges have no effect.

Reset
REQ-021 While clear=1 at a rising edge, the next state SHALL be S0 and the counter SHALL be 0, giving hwy=GREEN and cntry=RED; clear overrides x and any in-progress dwell.
REQ-022 Outputs SHALL hold S0 values for every cycle that clear remains high.
REQ-023 A clear asserted in any state, at any count, SHALL return the FSM to S0 at the next edge.

Structure
REQ-024 A shared package SHALL hold:
- the light codes RED, YELLOW and GREEN;
- the state enumeration S0..S4 (3-bit);
- the default delay constants.
REQ-025 The dwell timer SHALL be one sub-module named signal_timer, with inputs clk, clear, restart, delay and an output done.
REQ-026 The FSM next-state logic, state register and output decode SHALL reside in signal_controller.

Verification
REQ-027 Reset: clear=1 for 5 edges with x=0 -> hwy=2, cntry=0 throughout and after release.
REQ-028 Idle: clear=0 and x=0 for 10 cycles -> the FSM stays in S0 (hwy=2, cntry=0).
REQ-029 Full cycle with defaults:
- stimulus: x rises after reset release and is held 25 cycles, then x=0;
- response: hwy=1 for 3 cycles, then hwy=0/cntry=0 for 2 cycles, then cntry=2 until x falls;
- then cntry=1 for 3 cycles, then hwy=2/cntry=0.
REQ-030 One-cycle x pulse in S0 -> full S1 then S2 sequence, S3 for exactly 1 cycle, S4 for 3 cycles, then back to S0.
REQ-031 clear=1 for one edge while in S3 with x=1 -> S0 outputs at the next cycle; S1 follows at the next edge because x is still 1.
REQ-032 Parameters Y2R_DELAY=1 and R2G_DELAY=4 -> S1 and S4 each last 1 cycle and S2 lasts 4 cycles.

Source files
------------

// File: rtl/signal_controller_pkg.sv
// rtl/signal_controller_pkg.sv - shared light codes, states and delay constants for the traffic controller
package signal_controller_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,  // highway green
        S1 = 3'd1,  // highway yellow
        S2 = 3'd2,  // all red
        S3 = 3'd3,  // country green
        S4 = 3'd4   // country yellow
    } state_t;

    localparam int DEF_Y2R_DELAY = 3;
    localparam int DEF_R2G_DELAY = 2;
    localparam int DLY_W         = 8;

    function automatic light_t hwy_of(input state_t s);
        case (s)
            S0:      return GREEN;
            S1:      return YELLOW;
            default: return RED;
        endcase
    endfunction

    function automatic light_t cntry_of(input state_t s);
        case (s)
            S3:      return GREEN;
            S4:      return YELLOW;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/signal_timer.sv
// rtl/signal_timer.sv - dwell counter that flags the last cycle of a timed state
module signal_timer
    import signal_controller_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             restart,
    input  logic [DLY_W-1:0] delay,
    output logic             done
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    // done marks the final cycle of the dwell, so the owner leaves on this edge
    assign done = (cnt_q == delay - DLY_W'(1));

    // count up from zero after each restart; hold once the end is reached
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + DLY_W'(1);
        end
    end

    // counter register with synchronous clear
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/signal_controller.sv
// rtl/signal_controller.sv - highway/country-road traffic light Moore FSM
module signal_controller
    import signal_controller_pkg::*;
#(
    parameter int Y2R_DELAY = DEF_Y2R_DELAY,
    parameter int R2G_DELAY = DEF_R2G_DELAY
) (
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    input  logic       x,
    input  logic       clear,
    input  logic       clk
);

    localparam logic [DLY_W-1:0] Y2R_CYC = DLY_W'(Y2R_DELAY);
    localparam logic [DLY_W-1:0] R2G_CYC = DLY_W'(R2G_DELAY);

    state_t           state_q;
    state_t           state_d;
    light_t           hwy_q;
    light_t           hwy_d;
    light_t           cntry_q;
    light_t           cntry_d;
    logic [DLY_W-1:0] dwell;
    logic             restart;
    logic             timer_done;

    // the all-red state uses its own dwell; both yellow states share the other
    always_comb begin
        dwell = (state_q == S2) ? R2G_CYC : Y2R_CYC;
    end

    // a state change restarts the dwell count so every entry starts at zero
    assign restart = (state_d != state_q);

    signal_timer u_timer (
        .clk     (clk),
        .clear   (clear),
        .restart (restart),
        .delay   (dwell),
        .done    (timer_done)
    );

    // next state and the light codes that go with it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0:      if (x)          state_d = S1;
            S1:      if (timer_done) state_d = S2;
            S2:      if (timer_done) state_d = S3;
            S3:      if (!x)         state_d = S4;
            S4:      if (timer_done) state_d = S0;
            default:                 state_d = S0;
        endcase
        hwy_d   = hwy_of(state_d);
        cntry_d = cntry_of(state_d);
    end

    // state and registered light outputs; clear forces highway green
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S0;
            hwy_q   <= GREEN;
            cntry_q <= RED;
        end else begin
            state_q <= state_d;
            hwy_q   <= hwy_d;
            cntry_q <= cntry_d;
        end
    end

    assign hwy   = hwy_q;
    assign cntry = cntry_q;

endmodule

// File: tb/tb_signal_controller.sv
// tb/tb_signal_controller.sv - self-checking bench for signal_controller
module tb_signal_controller;

    logic       clk;
    logic       x;
    logic       clear;
    logic [1:0] hwy_a;
    logic [1:0] cntry_a;
    logic [1:0] hwy_b;
    logic [1:0] cntry_b;

    int errors;
    int checks;

    signal_controller dut_a (
        .hwy   (hwy_a),
        .cntry (cntry_a),
        .x     (x),
        .clear (clear),
        .clk   (clk)
    );

    signal_controller #(.Y2R_DELAY(1), .R2G_DELAY(4)) dut_b (
        .hwy   (hwy_b),
        .cntry (cntry_b),
        .x     (x),
        .clear (clear),
        .clk   (clk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: phase 0..4 and how many whole cycles it has been held
    int ph[2];
    int age[2];
    int y_dly[2] = '{3, 1};
    int r_dly[2] = '{2, 4};
    int hwy_tab[5]   = '{2, 1, 0, 0, 0};
    int cntry_tab[5] = '{0, 0, 0, 2, 1};

    typedef struct {
        logic       x;
        logic       clr;
        logic [1:0] h;
        logic [1:0] c;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic xi, input logic ci, input logic [1:0] h, input logic [1:0] c, input int n);
        vec_t v;
        v.x = xi; v.clr = ci; v.h = h; v.c = c;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic xi, input logic ci);
        int dwell;
        for (int i = 0; i < 2; i++) begin
            if (ci) begin
                ph[i] = 0; age[i] = 0;
            end else if (ph[i] == 0) begin
                if (xi) begin ph[i] = 1; age[i] = 0; end
            end else if (ph[i] == 3) begin
                if (!xi) begin ph[i] = 4; age[i] = 0; end
            end else begin
                dwell = (ph[i] == 2) ? r_dly[i] : y_dly[i];
                if (age[i] + 1 >= dwell) begin
                    ph[i] = (ph[i] + 1) % 5; age[i] = 0;
                end else begin
                    age[i]++;
                end
            end
        end
    endtask

    task automatic tick();
        model_step(x, clear);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        check("model_hwy_a",   int'(hwy_a),   hwy_tab[ph[0]]);
        check("model_cntry_a", int'(cntry_a), cntry_tab[ph[0]]);
        check("model_hwy_b",   int'(hwy_b),   hwy_tab[ph[1]]);
        check("model_cntry_b", int'(cntry_b), cntry_tab[ph[1]]);
    endtask

    initial begin
        int eh[10] = '{1, 1, 0, 0, 0, 0, 0, 0, 2, 2};
        int ec[10] = '{0, 0, 0, 0, 2, 1, 1, 1, 0, 0};
        logic v;
        errors = 0;
        checks = 0;
        ph  = '{0, 0};
        age = '{0, 0};
        x     = 1'b0;
        clear = 1'b1;

        // reset, idle, full cycle with default delays (dut_a expectations)
        add(1'b0, 1'b1, 2'd2, 2'd0, 5);
        add(1'b0, 1'b0, 2'd2, 2'd0, 10);
        add(1'b1, 1'b0, 2'd1, 2'd0, 3);
        add(1'b1, 1'b0, 2'd0, 2'd0, 2);
        add(1'b1, 1'b0, 2'd0, 2'd2, 20);
        add(1'b0, 1'b0, 2'd0, 2'd1, 3);
        add(1'b0, 1'b0, 2'd2, 2'd0, 4);

        foreach (vecs[i]) begin
            x     = vecs[i].x;
            clear = vecs[i].clr;
            tick();
            check($sformatf("vec%0d_hwy", i),   int'(hwy_a),   int'(vecs[i].h));
            check($sformatf("vec%0d_cntry", i), int'(cntry_a), int'(vecs[i].c));
            check_model();
        end

        // one-cycle x pulse from S0
        x = 1'b1;
        tick();
        check("pulse_s1_hwy", int'(hwy_a), 1);
        check_model();
        x = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("pulse%0d_hwy", i),   int'(hwy_a),   eh[i]);
            check($sformatf("pulse%0d_cntry", i), int'(cntry_a), ec[i]);
            check_model();
        end

        // clear during S3 with x held high
        x = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_model();
        end
        check("s3_before_clear_cntry", int'(cntry_a), 2);
        clear = 1'b1;
        tick();
        check("clear_in_s3_hwy",   int'(hwy_a),   2);
        check("clear_in_s3_cntry", int'(cntry_a), 0);
        check_model();
        clear = 1'b0;
        tick();
        check("after_clear_s1_hwy", int'(hwy_a), 1);
        check_model();

        // short yellow / long all-red instance timing
        clear = 1'b1;
        x = 1'b0;
        tick();
        clear = 1'b0;
        x = 1'b1;
        tick();
        check("b_s1_hwy", int'(hwy_b), 1);
        check_model();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b_s2_%0d_hwy", i),   int'(hwy_b),   0);
            check($sformatf("b_s2_%0d_cntry", i), int'(cntry_b), 0);
            check_model();
        end
        tick();
        check("b_s3_cntry", int'(cntry_b), 2);
        check_model();
        x = 1'b0;
        tick();
        check("b_s4_cntry", int'(cntry_b), 1);
        check_model();
        tick();
        check("b_s0_hwy", int'(hwy_b), 2);
        check_model();

        // random traffic with glitches between edges
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 3) != 0) ? ph[0][0] ^ ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 59) == 0);
            x = ~v;
            #2;
            x = v;
            tick();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
